// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes, FSM encoding and timeout default for the 8-way round-robin arbiter
package rr_arb_pkg;
  localparam int NREQ = 8;
  localparam int IDX_W = 3;
  localparam int TIMEOUT_DEF = 15;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: round-robin search, first set req bit after ptr (ptr+1 .. ptr, wrapping); ports req/ptr in, any/idx out
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    any = |req;
    idx = ptr;
    for (int k = NREQ; k >= 1; k--)
      if (req[ptr + IDX_W'(k)]) idx = ptr + IDX_W'(k);
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter (clk, async rst, req[7:0], ack -> en, in[2:0], busy, timeout); RR_TIMEOUT_EN adds forced release after TIMEOUT cycles
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             ack,
  output logic             en,
  output logic [IDX_W-1:0] in,
  output logic             busy,
  output logic             timeout
);
  state_t state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, in_nx, pick_ptr, idx;
  logic [NREQ-1:0] pick_req;
  logic any, expire;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be 1..255");
  end
  assign busy = state == GRANT;
  assign en = busy;
  // one picker serves both the idle search and the back-to-back search from the acked index
  assign pick_req = busy ? req & ~(NREQ'(1) << in) : req;
  assign pick_ptr = busy ? in : ptr;
  rr_pick8 u_pick (.req(pick_req), .ptr(pick_ptr), .any(any), .idx(idx));
`ifdef RR_TIMEOUT_EN
  logic [7:0] cnt;
  assign expire = busy && !ack && req[in] && cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 8'd0;
      timeout <= 1'b0;
    end else begin
      cnt <= busy && !ack ? cnt + 8'd1 : 8'd0;
      timeout <= expire;
    end
`else
  assign expire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= 3'd7;
      in <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      in <= in_nx;
    end
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    in_nx = in;
    if (!busy) begin
      state_nx = any ? GRANT : IDLE;
      in_nx = any ? idx : in;
    end else if (ack) begin
      ptr_nx = in;
      state_nx = any ? GRANT : IDLE;
      in_nx = any ? idx : in;
    end else if (!req[in]) begin
      state_nx = IDLE;
    end else if (expire) begin
      state_nx = IDLE;
      ptr_nx = in;
    end
  end
endmodule
